// File: rtl/mmss_timer.sv
// mm:ss up/down timer with one-second prescaler, preset load and terminal-value finish.
// Build option: define TIMER_AUTORELOAD_EN to pulse finish and reload the preset instead of halting.
module mmss_timer #(
  parameter int unsigned CLK_DIV = 100000000,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned MIN_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             forward,
  input  logic             load,
  input  logic [MIN_W-1:0] presetMinutes,
  input  logic [5:0]       presetSeconds,
  output logic [5:0]       outSeconds,
  output logic [MIN_W-1:0] outMinutes,
  output logic             secTick,
  output logic             minutesClock,
  output logic             finish
);

  localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);
  localparam logic [5:0]       SEC_TOP  = 6'd59;

  logic [PRE_W-1:0] pre_q;
  logic [5:0]       sec_q;
  logic [MIN_W-1:0] min_q;
  logic             tick_q;
  logic             mclk_q;
  logic             finish_q;

  logic             halted;
  logic             pre_wrap;
  logic             step;
  logic [5:0]       load_sec;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       adv_sec;
  logic [MIN_W-1:0] adv_min;
  logic [5:0]       nxt_sec;
  logic [MIN_W-1:0] nxt_min;
  logic             hits_terminal;

`ifdef TIMER_AUTORELOAD_EN
  // The preset register only matters when a terminal value is followed by a reload.
  logic [5:0]       preset_sec_q;
  logic [MIN_W-1:0] preset_min_q;
  logic             reload_q;
`endif

  always_comb begin
`ifdef TIMER_AUTORELOAD_EN
    halted = 1'b0;
`else
    halted = finish_q;
`endif
    pre_wrap = (pre_q == PRE_LAST);
    step     = enable && !halted && pre_wrap;
    load_sec = (presetSeconds > SEC_TOP) ? SEC_TOP : presetSeconds;
    load_min = (presetMinutes > MIN_TOP) ? MIN_TOP : presetMinutes;
  end

  always_comb begin
    adv_sec = sec_q;
    adv_min = min_q;
    if (forward) begin
      if (sec_q >= SEC_TOP) begin
        adv_sec = '0;
        adv_min = (min_q >= MIN_TOP) ? '0 : min_q + MIN_W'(1);
      end else begin
        adv_sec = sec_q + 6'd1;
      end
    end else begin
      if (sec_q == '0) begin
        adv_sec = SEC_TOP;
        adv_min = (min_q == '0) ? MIN_TOP : min_q - MIN_W'(1);
      end else begin
        adv_sec = sec_q - 6'd1;
      end
    end

    nxt_sec = adv_sec;
    nxt_min = adv_min;
`ifdef TIMER_AUTORELOAD_EN
    if (reload_q) begin
      nxt_sec = preset_sec_q;
      nxt_min = preset_min_q;
    end
`endif

    hits_terminal = forward ? ((nxt_sec == SEC_TOP) && (nxt_min == MIN_TOP))
                            : ((nxt_sec == '0) && (nxt_min == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q    <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      tick_q   <= 1'b0;
      mclk_q   <= 1'b0;
      finish_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      preset_sec_q <= '0;
      preset_min_q <= '0;
      reload_q     <= 1'b0;
`endif
    end else if (load) begin
      pre_q    <= '0;
      sec_q    <= load_sec;
      min_q    <= load_min;
      tick_q   <= 1'b0;
      mclk_q   <= 1'b0;
      finish_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      preset_sec_q <= load_sec;
      preset_min_q <= load_min;
      reload_q     <= 1'b0;
`endif
    end else begin
      tick_q <= step;
      mclk_q <= step && (nxt_min != min_q);

      if (halted) begin
        pre_q <= '0;
      end else if (enable) begin
        pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      end

      if (step) begin
        sec_q <= nxt_sec;
        min_q <= nxt_min;
      end

`ifdef TIMER_AUTORELOAD_EN
      finish_q <= step && hits_terminal;
      if (step) begin
        reload_q <= hits_terminal;
      end
`else
      if (step && hits_terminal) begin
        finish_q <= 1'b1;
      end
`endif
    end
  end

  assign outSeconds   = sec_q;
  assign outMinutes   = min_q;
  assign secTick      = tick_q;
  assign minutesClock = mclk_q;
  assign finish       = finish_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer with CLK_DIV=4, MIN_MAX=2; follows TIMER_AUTORELOAD_EN if defined.
module tb_mmss_timer;

  localparam int unsigned MIN_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             forward;
  logic             load;
  logic [MIN_W-1:0] presetMinutes;
  logic [5:0]       presetSeconds;
  logic [5:0]       outSeconds;
  logic [MIN_W-1:0] outMinutes;
  logic             secTick;
  logic             minutesClock;
  logic             finish;

  int total = 0;
  int bad   = 0;

  mmss_timer #(
    .CLK_DIV(4),
    .MIN_MAX(2),
    .MIN_W  (MIN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .forward      (forward),
    .load         (load),
    .presetMinutes(presetMinutes),
    .presetSeconds(presetSeconds),
    .outSeconds   (outSeconds),
    .outMinutes   (outMinutes),
    .secTick      (secTick),
    .minutesClock (minutesClock),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int m, input int s);
    chk({tag, ".min"}, 32'(outMinutes), 32'(m));
    chk({tag, ".sec"}, 32'(outSeconds), 32'(s));
  endtask

  task automatic do_load(input int m, input int s);
    presetMinutes = MIN_W'(m);
    presetSeconds = 6'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; forward = 1'b1; load = 1'b0;
    presetMinutes = '0; presetSeconds = '0;
    ticks(2);
    reset = 1'b0;
    chk_val("reset", 0, 0);
    chk("reset.tick", 32'(secTick), 0);
    chk("reset.mclk", 32'(minutesClock), 0);
    chk("reset.finish", 32'(finish), 0);

    // counting up from reset, first step after 4 enabled cycles
    enable = 1'b1;
    ticks(3);
    chk("up.no_tick_yet", 32'(secTick), 0);
    tick();
    chk("up.first_tick", 32'(secTick), 1);
    chk_val("up.first", 0, 1);
    ticks(58 * 4);
    chk_val("up.59", 0, 59);
    chk("up.59.mclk", 32'(minutesClock), 0);
    ticks(4);
    chk_val("up.carry", 1, 0);
    chk("up.carry.mclk", 32'(minutesClock), 1);
    chk("up.carry.tick", 32'(secTick), 1);
    tick();
    chk("up.mclk_drop", 32'(minutesClock), 0);
    chk("up.tick_drop", 32'(secTick), 0);

    // forward to terminal 02:59
    do_load(2, 58);
    chk_val("ld258", 2, 58);
    chk("ld258.finish", 32'(finish), 0);
    ticks(4);
    chk_val("term_up", 2, 59);
    chk("term_up.finish", 32'(finish), 1);
    chk("term_up.tick", 32'(secTick), 1);
`ifndef TIMER_AUTORELOAD_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt.tick", 32'(secTick), 0);
    end
    chk_val("halt.frozen", 2, 59);
    chk("halt.finish", 32'(finish), 1);
`endif

    // backward to terminal 00:00, then load clears finish
    forward = 1'b0;
    do_load(0, 2);
    chk("ld002.finish", 32'(finish), 0);
    ticks(4);
    chk_val("dn.1", 0, 1);
    chk("dn.1.finish", 32'(finish), 0);
    ticks(4);
    chk_val("dn.0", 0, 0);
    chk("dn.0.finish", 32'(finish), 1);
    chk("dn.0.mclk", 32'(minutesClock), 0);
    do_load(1, 30);
    chk_val("ld130", 1, 30);
    chk("ld130.finish", 32'(finish), 0);

    // saturating load; a loaded terminal value wraps without finish
    forward = 1'b1;
    do_load(7, 63);
    chk_val("sat", 2, 59);
    chk("sat.finish", 32'(finish), 0);
    ticks(4);
    chk_val("wrap_up", 0, 0);
    chk("wrap_up.mclk", 32'(minutesClock), 1);
    chk("wrap_up.finish", 32'(finish), 0);
    forward = 1'b0;
    do_load(0, 0);
    ticks(4);
    chk_val("wrap_dn", 2, 59);
    chk("wrap_dn.mclk", 32'(minutesClock), 1);
    chk("wrap_dn.finish", 32'(finish), 0);

    // enable dropped at prescaler=2 holds the partial count
    forward = 1'b1;
    do_load(1, 0);
    ticks(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.tick", 32'(secTick), 0);
    end
    chk_val("hold", 1, 0);
    enable = 1'b1;
    tick();
    chk("resume.1", 32'(secTick), 0);
    tick();
    chk("resume.2", 32'(secTick), 1);
    chk_val("resume", 1, 1);

    // load on a would-be step edge suppresses the step
    ticks(3);
    do_load(0, 10);
    chk_val("ld_step", 0, 10);
    chk("ld_step.tick", 32'(secTick), 0);
    ticks(4);
    chk_val("after_ld", 0, 11);
    chk("after_ld.tick", 32'(secTick), 1);

    // reset right before a step discards the count and the pulse
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_val("mid_rst", 0, 0);
    chk("mid_rst.tick", 32'(secTick), 0);
    chk("mid_rst.mclk", 32'(minutesClock), 0);
    ticks(3);
    chk("mid_rst.no_tick", 32'(secTick), 0);
    tick();
    chk("mid_rst.tick4", 32'(secTick), 1);
    chk_val("mid_rst.step", 0, 1);

`ifdef TIMER_AUTORELOAD_EN
    forward = 1'b0;
    do_load(0, 1);
    ticks(4);
    chk_val("ar.term", 0, 0);
    chk("ar.finish", 32'(finish), 1);
    tick();
    chk("ar.finish_drop", 32'(finish), 0);
    ticks(3);
    chk_val("ar.reload", 0, 1);
    chk("ar.reload.tick", 32'(secTick), 1);
    chk("ar.reload.finish", 32'(finish), 0);
    chk("ar.reload.mclk", 32'(minutesClock), 0);
    ticks(4);
    chk_val("ar.term2", 0, 0);
    chk("ar.finish2", 32'(finish), 1);
    ticks(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_val("ar.rst", 0, 0);
    chk("ar.rst.tick", 32'(secTick), 0);
    chk("ar.rst.finish", 32'(finish), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
